// File: rtl/seg_mmio.sv
// seg_mmio: bus front end for the 16-digit seven-segment display driver.
// The CPU writes shadow registers over a single-outstanding req/ack bus.
// A commit, or AUTO mode, copies the shadows onto the live display words.
// Optional feature macro SEG_MMIO_BCD_EN adds a sequential double-dabble
// binary-to-BCD converter at register 0x0C. Without the macro, 0x0C is
// treated as an unmapped address.
module seg_mmio #(
    parameter int unsigned CONV_BITS = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        ack,
    output logic [15:0] data_A,
    output logic [15:0] data_B,
    output logic [15:0] data_C,
    output logic [15:0] data_D
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1
`ifdef SEG_MMIO_BCD_EN
        ,
        ST_CONV = 2'd2
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] shd_ab_q, shd_ab_d;
    logic [31:0] shd_cd_q, shd_cd_d;
    logic        auto_q, auto_d;
    logic [15:0] live_a_q, live_a_d;
    logic [15:0] live_b_q, live_b_d;
    logic [15:0] live_c_q, live_c_d;
    logic [15:0] live_d_q, live_d_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] read_mux;
    logic        bcd_write;
    logic        unused_ok;

`ifdef SEG_MMIO_BCD_EN
    localparam int unsigned CNT_W = $clog2(CONV_BITS + 1);

    logic [CONV_BITS-1:0] bin_q, bin_d;
    logic [CONV_BITS-1:0] bin_shift;
    logic [15:0]          bcd_q, bcd_d;
    logic [15:0]          bcd_adj;
    logic [15:0]          bcd_shift;
    logic [15:0]          bcd_result;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           tgt_q, tgt_d;
    logic                 sat_q, sat_d;

    // Double-dabble step: add 3 to every digit >= 5, then shift in the next operand bit.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift  = {bcd_adj[14:0], bin_q[CONV_BITS-1]};
        bin_shift  = bin_q << 1;
        bcd_result = sat_q ? 16'h9999 : bcd_shift;
    end

    assign bcd_write = we && (addr[4:2] == 3'd3);
    assign unused_ok = ^{addr[1:0], bcd_adj[15]} ^ (CONV_BITS == 0);
`else
    assign bcd_write = 1'b0;
    assign unused_ok = ^addr[1:0] ^ bcd_write ^ (CONV_BITS == 0);
`endif

    // Read data mux; the BCD register and unmapped addresses read as zero.
    always_comb begin
        read_mux = 32'h0;
        case (addr[4:2])
            3'd0:    read_mux = shd_ab_q;
            3'd1:    read_mux = shd_cd_q;
            3'd2:    read_mux = {30'b0, auto_q, 1'b0};
            default: read_mux = 32'h0;
        endcase
    end

    // Next-state and register-update logic for the bus FSM and converter.
    always_comb begin
        state_d  = state_q;
        shd_ab_d = shd_ab_q;
        shd_cd_d = shd_cd_q;
        auto_d   = auto_q;
        live_a_d = live_a_q;
        live_b_d = live_b_q;
        live_c_d = live_c_q;
        live_d_d = live_d_q;
        rdata_d  = 32'h0;
`ifdef SEG_MMIO_BCD_EN
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        tgt_d    = tgt_q;
        sat_d    = sat_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (bcd_write) begin
`ifdef SEG_MMIO_BCD_EN
                        bin_d   = wdata[CONV_BITS-1:0];
                        sat_d   = 32'(wdata[CONV_BITS-1:0]) > 32'd9999;
                        tgt_d   = wdata[17:16];
                        bcd_d   = 16'h0;
                        cnt_d   = '0;
                        state_d = ST_CONV;
`endif
                    end else begin
                        state_d = ST_ACK;
                        if (we) begin
                            case (addr[4:2])
                                3'd0: begin
                                    for (int b = 0; b < 4; b++) begin
                                        if (wstrb[b]) shd_ab_d[8*b +: 8] = wdata[8*b +: 8];
                                    end
                                    if (auto_q && (|wstrb[1:0])) live_a_d = shd_ab_d[15:0];
                                    if (auto_q && (|wstrb[3:2])) live_b_d = shd_ab_d[31:16];
                                end
                                3'd1: begin
                                    for (int b = 0; b < 4; b++) begin
                                        if (wstrb[b]) shd_cd_d[8*b +: 8] = wdata[8*b +: 8];
                                    end
                                    if (auto_q && (|wstrb[1:0])) live_c_d = shd_cd_d[15:0];
                                    if (auto_q && (|wstrb[3:2])) live_d_d = shd_cd_d[31:16];
                                end
                                3'd2: begin
                                    if (wstrb[0]) begin
                                        auto_d = wdata[1];
                                        if (wdata[0]) begin
                                            live_a_d = shd_ab_q[15:0];
                                            live_b_d = shd_ab_q[31:16];
                                            live_c_d = shd_cd_q[15:0];
                                            live_d_d = shd_cd_q[31:16];
                                        end
                                    end
                                end
                                default: ;
                            endcase
                        end else begin
                            rdata_d = read_mux;
                        end
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
`ifdef SEG_MMIO_BCD_EN
            ST_CONV: begin
                bcd_d = bcd_shift;
                bin_d = bin_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(CONV_BITS - 1)) begin
                    state_d = ST_ACK;
                    case (tgt_q)
                        2'd0: begin
                            shd_ab_d[15:0] = bcd_result;
                            if (auto_q) live_a_d = bcd_result;
                        end
                        2'd1: begin
                            shd_ab_d[31:16] = bcd_result;
                            if (auto_q) live_b_d = bcd_result;
                        end
                        2'd2: begin
                            shd_cd_d[15:0] = bcd_result;
                            if (auto_q) live_c_d = bcd_result;
                        end
                        default: begin
                            shd_cd_d[31:16] = bcd_result;
                            if (auto_q) live_d_d = bcd_result;
                        end
                    endcase
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and register flops with synchronous reset that also aborts a conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            shd_ab_q <= 32'h0;
            shd_cd_q <= 32'h0;
            auto_q   <= 1'b0;
            live_a_q <= 16'h0;
            live_b_q <= 16'h0;
            live_c_q <= 16'h0;
            live_d_q <= 16'h0;
            rdata_q  <= 32'h0;
`ifdef SEG_MMIO_BCD_EN
            bin_q    <= '0;
            bcd_q    <= 16'h0;
            cnt_q    <= '0;
            tgt_q    <= 2'd0;
            sat_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shd_ab_q <= shd_ab_d;
            shd_cd_q <= shd_cd_d;
            auto_q   <= auto_d;
            live_a_q <= live_a_d;
            live_b_q <= live_b_d;
            live_c_q <= live_c_d;
            live_d_q <= live_d_d;
            rdata_q  <= rdata_d;
`ifdef SEG_MMIO_BCD_EN
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            tgt_q    <= tgt_d;
            sat_q    <= sat_d;
`endif
        end
    end

    assign ack    = (state_q == ST_ACK);
    assign rdata  = rdata_q;
    assign data_A = live_a_q;
    assign data_B = live_b_q;
    assign data_C = live_c_q;
    assign data_D = live_d_q;

endmodule

// File: tb/tb_seg_mmio.sv
// tb_seg_mmio: directed self-checking bench for seg_mmio.
// The BCD section follows the SEG_MMIO_BCD_EN build option of the design.
module tb_seg_mmio;

    localparam int CYCLE_LIMIT = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  addr = 5'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic [31:0] rdata;
    logic        ack;
    logic [15:0] data_A, data_B, data_C, data_D;

    int errors = 0;
    int checks = 0;

    seg_mmio dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .wstrb  (wstrb),
        .rdata  (rdata),
        .ack    (ack),
        .data_A (data_A),
        .data_B (data_B),
        .data_C (data_C),
        .data_D (data_D)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if the observed value differs.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // One bus transaction; returns read data and the number of cycles until ack.
    task automatic applyStimulus(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                                 input logic [3:0] ws, output logic [31:0] rd, output int cyc);
        @(negedge clk);
        req = 1'b1; we = wr; addr = a; wdata = wd; wstrb = ws;
        cyc = 0;
        rd  = 32'h0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ack && cyc < CYCLE_LIMIT);
        if (ack) rd = rdata;
        else checkOutput("ack_timeout", 32'(ack), 32'd1);
        req = 1'b0; we = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          cyc;
        int          ackSeen;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_data_A", 32'(data_A), 32'h0);
        checkOutput("rst_data_B", 32'(data_B), 32'h0);
        checkOutput("rst_data_C", 32'(data_C), 32'h0);
        checkOutput("rst_data_D", 32'(data_D), 32'h0);
        checkOutput("rst_ack", 32'(ack), 32'h0);
        checkOutput("rst_rdata", rdata, 32'h0);
        rst = 1'b0;

        applyStimulus(1'b0, 5'h08, 32'h0, 4'h0, rd, cyc);
        checkOutput("rd_ctrl_rst", rd, 32'h0);
        checkOutput("rd_ctrl_lat", 32'(cyc), 32'd1);

        applyStimulus(1'b1, 5'h00, 32'h1234_ABCD, 4'hF, rd, cyc);
        checkOutput("wr_ab_lat", 32'(cyc), 32'd1);
        checkOutput("wr_ab_liveA", 32'(data_A), 32'h0);
        checkOutput("wr_ab_liveB", 32'(data_B), 32'h0);

        applyStimulus(1'b1, 5'h08, 32'h1, 4'h1, rd, cyc);
        checkOutput("commit_A", 32'(data_A), 32'hABCD);
        checkOutput("commit_B", 32'(data_B), 32'h1234);
        applyStimulus(1'b0, 5'h00, 32'h0, 4'h0, rd, cyc);
        checkOutput("rd_ab", rd, 32'h1234_ABCD);

        applyStimulus(1'b1, 5'h04, 32'hFFFF_FFFF, 4'h3, rd, cyc);
        applyStimulus(1'b1, 5'h04, 32'hFFFF_FFFF, 4'h4, rd, cyc);
        applyStimulus(1'b0, 5'h04, 32'h0, 4'h0, rd, cyc);
        checkOutput("rd_cd_strb", rd, 32'h00FF_FFFF);
        checkOutput("strb_liveC", 32'(data_C), 32'h0);
        checkOutput("strb_liveD", 32'(data_D), 32'h0);

        applyStimulus(1'b1, 5'h08, 32'h2, 4'h1, rd, cyc);
        applyStimulus(1'b1, 5'h04, 32'h0000_5A5A, 4'hF, rd, cyc);
        checkOutput("auto_liveC", 32'(data_C), 32'h5A5A);
        checkOutput("auto_liveD", 32'(data_D), 32'h0);
        checkOutput("auto_liveA", 32'(data_A), 32'hABCD);
        applyStimulus(1'b0, 5'h08, 32'h0, 4'h0, rd, cyc);
        checkOutput("rd_ctrl_auto", rd, 32'h2);
        applyStimulus(1'b1, 5'h08, 32'h0, 4'h0, rd, cyc);
        applyStimulus(1'b0, 5'h08, 32'h0, 4'h0, rd, cyc);
        checkOutput("ctrl_nostrb", rd, 32'h2);

        applyStimulus(1'b1, 5'h14, 32'hFFFF_FFFF, 4'hF, rd, cyc);
        checkOutput("unmap_wr_lat", 32'(cyc), 32'd1);
        applyStimulus(1'b0, 5'h14, 32'h0, 4'h0, rd, cyc);
        checkOutput("unmap_rd", rd, 32'h0);
        applyStimulus(1'b0, 5'h00, 32'h0, 4'h0, rd, cyc);
        checkOutput("unmap_ab_kept", rd, 32'h1234_ABCD);

`ifdef SEG_MMIO_BCD_EN
        applyStimulus(1'b1, 5'h08, 32'h0, 4'h1, rd, cyc);
        applyStimulus(1'b1, 5'h0C, 32'h0003_04D2, 4'h0, rd, cyc);
        checkOutput("bcd_lat", 32'(cyc), 32'd15);
        checkOutput("bcd_noauto_D", 32'(data_D), 32'h0);
        applyStimulus(1'b0, 5'h04, 32'h0, 4'h0, rd, cyc);
        checkOutput("bcd_shd_cd", rd, 32'h1234_5A5A);
        applyStimulus(1'b1, 5'h08, 32'h1, 4'h1, rd, cyc);
        checkOutput("bcd_commit_D", 32'(data_D), 32'h1234);
        applyStimulus(1'b1, 5'h0C, 32'h0000_2EE0, 4'h0, rd, cyc);
        applyStimulus(1'b0, 5'h00, 32'h0, 4'h0, rd, cyc);
        checkOutput("bcd_sat", rd, 32'h1234_9999);
        applyStimulus(1'b1, 5'h08, 32'h2, 4'h1, rd, cyc);
        applyStimulus(1'b1, 5'h0C, 32'h0001_270F, 4'h0, rd, cyc);
        checkOutput("bcd_auto_B", 32'(data_B), 32'h9999);
        checkOutput("bcd_auto_A", 32'(data_A), 32'hABCD);
        applyStimulus(1'b1, 5'h0C, 32'h0002_0050, 4'h0, rd, cyc);
        checkOutput("bcd_auto_C", 32'(data_C), 32'h0080);

        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 5'h0C; wdata = 32'h0003_04D2; wstrb = 4'hF;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        ackSeen = 0;
        repeat (5) begin
            if (ack) ackSeen++;
            @(negedge clk);
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (ack) ackSeen++;
        end
        rst = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (ack) ackSeen++;
        end
        checkOutput("midconv_noack", 32'(ackSeen), 32'd0);
`else
        applyStimulus(1'b1, 5'h0C, 32'h0003_04D2, 4'hF, rd, cyc);
        checkOutput("bcd_off_lat", 32'(cyc), 32'd1);
        checkOutput("bcd_off_D", 32'(data_D), 32'h0);
        applyStimulus(1'b0, 5'h04, 32'h0, 4'h0, rd, cyc);
        checkOutput("bcd_off_cd", rd, 32'h0000_5A5A);
        applyStimulus(1'b0, 5'h0C, 32'h0, 4'h0, rd, cyc);
        checkOutput("bcd_off_rd", rd, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
`endif
        checkOutput("rst2_data_A", 32'(data_A), 32'h0);
        checkOutput("rst2_data_B", 32'(data_B), 32'h0);
        checkOutput("rst2_data_C", 32'(data_C), 32'h0);
        checkOutput("rst2_data_D", 32'(data_D), 32'h0);
        applyStimulus(1'b0, 5'h00, 32'h0, 4'h0, rd, cyc);
        checkOutput("rst2_rd_lat", 32'(cyc), 32'd1);
        checkOutput("rst2_rd_ab", rd, 32'h0);
        applyStimulus(1'b0, 5'h08, 32'h0, 4'h0, rd, cyc);
        checkOutput("rst2_rd_ctrl", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_mmio.md
# seg_mmio

Memory-mapped front end for the 16-digit seven-segment display driver. The CPU writes display values over a single-outstanding request/ack bus into shadow registers. A commit copies the shadow values atomically onto the four 16-bit hex words consumed by the display scanner. An optional sequential binary-to-BCD converter lets software show decimal values without doing the division itself.

## Interface
Parameters:
- `CONV_BITS`, default 14: width of the binary operand accepted by the BCD converter; the maximum displayable value is 9999.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: bus request; held high by the master until `ack` is seen.
- `we` in 1: 1 = write, 0 = read; valid while `req` is high.
- `addr` in 5: byte address; `addr[1:0]` is ignored and `addr[4:2]` selects the register.
- `wdata` in 32: write data.
- `wstrb` in 4: byte write enables.
- `rdata` out 32: read data, valid only while `ack` is high.
- `ack` out 1: one-cycle completion pulse.
- `data_A`, `data_B`, `data_C`, `data_D` out 16 each: live display words, 4 hex nibbles per word.

## Operation
Register map:
- 0x00 `SHD_AB`: bits [15:0] are shadow A, bits [31:16] are shadow B. Read/write, byte-strobed.
- 0x04 `SHD_CD`: bits [15:0] are shadow C, bits [31:16] are shadow D. Read/write, byte-strobed.
- 0x08 `CTRL`:
  - bit0 `COMMIT`: write-1 copies all four shadows to live. Self-clearing; reads 0.
  - bit1 `AUTO`: when 1, every shadow update is also copied to the matching live word in the same edge.
  - Bits are written only when `wstrb[0]` is set. Reads return {30'b0, AUTO, 1'b0}.
- 0x0C `BCD`: write-only.
  - `wdata[CONV_BITS-1:0]` is the binary operand.
  - `wdata[17:16]` selects the target shadow: 0=A, 1=B, 2=C, 3=D.
  - The write always takes effect regardless of `wstrb`. Reads return 0.
- 0x10–0x1C: unmapped. Writes are ignored, reads return 0, and `ack` behaves normally.

FSM:
- **IDLE**: `req` high with any address other than a BCD write → perform the access and go to ACK. A BCD write → go to CONV.
- **CONV**: double-dabble, one shift per cycle for `CONV_BITS` cycles. After the last shift, write the 4-digit result into the target shadow (and live, if `AUTO`), then go to ACK.
- **ACK**: `ack` is high for this one cycle → IDLE. `req` is not sampled in this state.

Rules:
- An operand greater than 9999 saturates to 16'h9999, detected at acceptance.
- A shadow write with `AUTO`=0 does not change the live words.
- A `CTRL` write with `COMMIT`=1 and `AUTO` changing: first set `AUTO`, then commit. Live ends up equal to shadow either way.
- Reset at any point, including mid-CONV: abort, go to IDLE, no `ack` issued. Shadows, live words and `AUTO` clear to 0.

## Timing
Reset values:
- `ack`=0 and `rdata`=0.
- `data_A`–`data_D` = 16'h0000.
- State = IDLE.

Normal read/write:
- `req` is sampled at edge E0.
- Register and live updates occur at E0.
- `ack` and `rdata` are high/valid in the cycle E0→E1.
- The master may drop `req` or present the next request at E1; the earliest next acceptance is E1.

BCD write:
- Accepted at E0; shifts occur on E1..E`CONV_BITS`.
- The result is written at edge E`CONV_BITS`.
- `ack` is high in the cycle after that edge: 15 cycles after E0 with the default parameter.

Live words are registered outputs with no combinational path from the bus.

## Configuration
- Macro `SEG_MMIO_BCD_EN`.
- **Defined**: the CONV state and converter are present, with behaviour as above.
- **Undefined**: no CONV state. A write to 0x0C behaves as an unmapped write (1-cycle `ack`, no effect), and the converter logic is absent.

## Test plan
- **Reset values**: hold `rst` for 3 cycles → all `data_*`=0, `ack`=0; read `CTRL` → 0.
- **Shadow write then commit**:
  - Write 0x00=32'h1234_ABCD with `wstrb`=4'hF → `ack` 1 cycle later; `data_A`/`data_B` stay 0.
  - Write `CTRL`=1 → `data_A`=16'hABCD, `data_B`=16'h1234.
  - Read 0x00 → 32'h1234_ABCD.
- **Partial strobe**:
  - Write 0x04=32'hFFFF_FFFF with `wstrb`=4'h3, then 4'h4 → `SHD_CD` reads 32'h00FF_FFFF.
- **AUTO mode**: `CTRL`=2, then write 0x04=32'h0000_5A5A → `data_C`=16'h5A5A at the acceptance edge with no commit; read `CTRL` → 2.
- **BCD conversion (macro defined)**:
  - Write 0x0C=32'h0003_04D2 (1234, target D) → `ack` 15 cycles after acceptance.
  - After commit, `data_D`=16'h1234.
  - Writing 12000 (saturation) → 16'h9999.
- **Reset mid-conversion**: assert `rst` 5 cycles into CONV → no `ack`, `data_*`=0; the next read is acked in 1 cycle. With the macro undefined, a 0x0C write is acked in 1 cycle and no state changes.
